// File: rtl/mcp_core.sv
// Multi-cycle MIPS-subset core sharing a single memory port for instruction fetch and data access.
// Latency: j/branch 3 cycles, sw and R-type/addi 4, lw 5 with an ack in the same cycle as the request; each ack wait adds one cycle.
// Backpressure: mem_req is held with a stable address and data until mem_ack; the FSM stalls in FETCH or MEM while it waits.
module mcp_core #(
  parameter int                   DATAWIDTH    = 32,
  parameter int                   ADDRESSWIDTH = 5,
  parameter logic [DATAWIDTH-1:0] RESET_PC     = '0
) (
  input  logic                 clk,
  input  logic                 rstb,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 halt,
  output logic [DATAWIDTH-1:0] pc
);

  localparam int NREGS = 2 ** ADDRESSWIDTH;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] ir;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] alu_out;
  logic [DATAWIDTH-1:0] mdr;
  logic [DATAWIDTH-1:0] regs [NREGS];

  // Instruction fields, all taken from the latched IR
  logic [5:0]              opcode;
  logic [5:0]              funct;
  logic [4:0]              shamt;
  logic [15:0]             imm;
  logic [25:0]             target;
  logic [ADDRESSWIDTH-1:0] rs_idx;
  logic [ADDRESSWIDTH-1:0] rt_idx;
  logic [ADDRESSWIDTH-1:0] rd_idx;

  assign opcode = ir[31:26];
  assign rs_idx = ADDRESSWIDTH'(ir[25:21]);
  assign rt_idx = ADDRESSWIDTH'(ir[20:16]);
  assign rd_idx = ADDRESSWIDTH'(ir[15:11]);
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  logic [DATAWIDTH-1:0] sext_imm;
  assign sext_imm = {{(DATAWIDTH-16){imm[15]}}, imm};

  // Instruction classes
  logic is_rtype, is_addi, is_lw, is_sw, is_j, is_branch;
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_j      = (opcode == OP_J);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BGTZ);

  // Flag opcodes/functs outside the supported subset so DECODE can stop the core
  logic legal;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL: legal = 1'b1;
          default:                                 legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Register file read ports; index 0 always reads as zero
  logic [DATAWIDTH-1:0] rd_a;
  logic [DATAWIDTH-1:0] rd_b;
  assign rd_a = (rs_idx == '0) ? '0 : regs[rs_idx];
  assign rd_b = (rt_idx == '0) ? '0 : regs[rt_idx];

  // ALU result for EXEC: R-type ops, or A + sext(imm) for addi and address generation
  logic                 slt_bit;
  logic [DATAWIDTH-1:0] alu_res;
  assign slt_bit = ($signed(a) < $signed(b));
  always_comb begin
    alu_res = '0;
    if (is_rtype) begin
      case (funct)
        F_ADD:   alu_res = a + b;
        F_SUB:   alu_res = a - b;
        F_AND:   alu_res = a & b;
        F_OR:    alu_res = a | b;
        F_SLT:   alu_res = {{(DATAWIDTH-1){1'b0}}, slt_bit};
        F_SLL:   alu_res = b << shamt;
        default: alu_res = '0;
      endcase
    end else begin
      alu_res = a + sext_imm;
    end
  end

  // Branch condition; bgtz treats A as signed and strictly positive
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BEQ:  br_taken = (a == b);
      OP_BNE:  br_taken = (a != b);
      OP_BGTZ: br_taken = !a[DATAWIDTH-1] && (a != '0);
      default: br_taken = 1'b0;
    endcase
  end

  // pc already points past the branch when EXEC runs, so offsets are relative to it
  logic [DATAWIDTH-1:0] pc_inc;
  logic [DATAWIDTH-1:0] br_target;
  logic [DATAWIDTH-1:0] j_target;
  assign pc_inc    = pc + DATAWIDTH'(4);
  assign br_target = pc + (sext_imm << 2);
  assign j_target  = {pc[DATAWIDTH-1:28], target, 2'b00};

  // Write-back destination: rd for R-type, rt for addi/lw; lw writes MDR
  logic [ADDRESSWIDTH-1:0] wb_idx;
  logic [DATAWIDTH-1:0]    wb_data;
  always_comb begin
    wb_idx  = '0;
    wb_data = alu_out;
    if (is_rtype) begin
      wb_idx = rd_idx;
    end else if (is_lw) begin
      wb_idx  = rt_idx;
      wb_data = mdr;
    end else if (is_addi) begin
      wb_idx = rt_idx;
    end
  end

  // Memory port is a pure decode of the registered state, so an immediate ack costs
  // no extra cycle; rstb gates it so an access is dropped the instant reset asserts.
  assign mem_req   = rstb && ((state == FETCH) || (state == MEM));
  assign mem_we    = rstb && (state == MEM) && is_sw;
  assign mem_addr  = (state == MEM) ? {alu_out[DATAWIDTH-1:2], 2'b00} : pc;
  assign mem_wdata = b;

  // Main control FSM: sequences fetch/decode/execute/memory/write-back and owns pc, IR, A, B, ALUOut, MDR, halt
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      halt    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc_inc;
            state <= DECODE;
          end
        end
        DECODE: begin
          a <= rd_a;
          b <= rd_b;
          if (legal) begin
            state <= EXEC;
          end else begin
            state <= HALT;
            halt  <= 1'b1;
          end
        end
        EXEC: begin
          if (is_branch) begin
            if (br_taken) begin
              pc <= br_target;
            end
            state <= FETCH;
          end else if (is_j) begin
            pc    <= j_target;
            state <= FETCH;
          end else if (is_lw || is_sw) begin
            alu_out <= alu_res;
            state   <= MEM;
          end else begin
            alu_out <= alu_res;
            state   <= WB;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (is_lw) begin
              mdr   <= mem_rdata;
              state <= WB;
            end else begin
              state <= FETCH;
            end
          end
        end
        WB: begin
          state <= FETCH;
        end
        HALT: begin
          state <= HALT;
          halt  <= 1'b1;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Register file write port: committed in WB, writes to index 0 are dropped
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == WB) && (wb_idx != '0)) begin
      regs[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mcp_core.sv
// Directed bench for mcp_core: small programs run from a behavioural memory with programmable ack delay.
// Latency: expected register/pc values are hand-computed per cycle count for each program.
// Backpressure: the memory model holds mem_ack low for ack_delay cycles of every request.
module tb_mcp_core;

  logic        clk;
  logic        rstb;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        halt;
  logic [31:0] pc;

  int tests_run;
  int tests_failed;

  // Program image (written by the test sequence) and live memory (owned by the responder)
  logic [31:0] prog [0:127];
  logic [31:0] mem  [0:127];
  int          ack_delay;
  int          wait_cnt;
  int          st_count;
  logic [31:0] st_addr;
  logic [31:0] st_data;

  mcp_core #(
    .DATAWIDTH   (32),
    .ADDRESSWIDTH(5),
    .RESET_PC    (32'h0)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .halt     (halt),
    .pc       (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acts 1ns after each falling edge so it never races the test sequence
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    st_count  = 0;
    st_addr   = '0;
    st_data   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstb) begin
        for (int i = 0; i < 128; i++) mem[i] = prog[i];
        mem_ack  = 1'b0;
        wait_cnt = 0;
        st_count = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[8:2]];
          if (mem_we) begin
            mem[mem_addr[8:2]] = mem_wdata;
            st_count++;
            st_addr = mem_addr;
            st_data = mem_wdata;
          end
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    clear_prog();
    ack_delay = 0;
    rstb = 1'b0;
    @(negedge clk);
    #1;
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    tests_run++; if (halt !== 1'b0) begin tests_failed++; $display("FAIL reset_halt: got %b expected 0", halt); end
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
  endtask

  task automatic test_arith();
    clear_prog();
    prog[0] = 32'h20010005; // addi $1,$0,5
    prog[1] = 32'h2002FFFD; // addi $2,$0,-3
    prog[2] = 32'h00221820; // add  $3,$1,$2
    ack_delay = 0;
    do_reset();
    run(11);
    tests_run++; if (dut.regs[3] !== 32'h0) begin tests_failed++; $display("FAIL arith_r3_early: got %h expected %h", dut.regs[3], 32'h0); end
    run(1);
    tests_run++; if (dut.regs[3] !== 32'h2) begin tests_failed++; $display("FAIL arith_r3: got %h expected %h", dut.regs[3], 32'h2); end
    tests_run++; if (dut.regs[2] !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL arith_r2: got %h expected %h", dut.regs[2], 32'hFFFFFFFD); end
    tests_run++; if (pc !== 32'd12) begin tests_failed++; $display("FAIL arith_pc: got %h expected %h", pc, 32'd12); end
  endtask

  task automatic test_alu();
    clear_prog();
    prog[0] = 32'h2001000C; // addi $1,$0,12
    prog[1] = 32'h2002000A; // addi $2,$0,10
    prog[2] = 32'h00221822; // sub  $3,$1,$2
    prog[3] = 32'h00222024; // and  $4,$1,$2
    prog[4] = 32'h00222825; // or   $5,$1,$2
    prog[5] = 32'h000230C0; // sll  $6,$2,3
    prog[6] = 32'h00413822; // sub  $7,$2,$1
    ack_delay = 0;
    do_reset();
    run(28);
    tests_run++; if (dut.regs[3] !== 32'd2) begin tests_failed++; $display("FAIL alu_sub: got %h expected %h", dut.regs[3], 32'd2); end
    tests_run++; if (dut.regs[4] !== 32'd8) begin tests_failed++; $display("FAIL alu_and: got %h expected %h", dut.regs[4], 32'd8); end
    tests_run++; if (dut.regs[5] !== 32'd14) begin tests_failed++; $display("FAIL alu_or: got %h expected %h", dut.regs[5], 32'd14); end
    tests_run++; if (dut.regs[6] !== 32'h50) begin tests_failed++; $display("FAIL alu_sll: got %h expected %h", dut.regs[6], 32'h50); end
    tests_run++; if (dut.regs[7] !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL alu_sub_wrap: got %h expected %h", dut.regs[7], 32'hFFFFFFFE); end
  endtask

  task automatic test_zero_slt();
    clear_prog();
    prog[0] = 32'h20000007; // addi $0,$0,7
    prog[1] = 32'h20050009; // addi $5,$0,9
    prog[2] = 32'h00002820; // add  $5,$0,$0
    prog[3] = 32'h2001FFFF; // addi $1,$0,-1
    prog[4] = 32'h20020001; // addi $2,$0,1
    prog[5] = 32'h0022302A; // slt  $6,$1,$2
    prog[6] = 32'h0041382A; // slt  $7,$2,$1
    ack_delay = 0;
    do_reset();
    tests_run++; if (dut.regs[3] !== 32'h0) begin tests_failed++; $display("FAIL reset_regfile: got %h expected %h", dut.regs[3], 32'h0); end
    run(8);
    tests_run++; if (dut.regs[5] !== 32'd9) begin tests_failed++; $display("FAIL zero_r5_pre: got %h expected %h", dut.regs[5], 32'd9); end
    run(20);
    tests_run++; if (dut.regs[0] !== 32'h0) begin tests_failed++; $display("FAIL zero_r0: got %h expected %h", dut.regs[0], 32'h0); end
    tests_run++; if (dut.regs[5] !== 32'h0) begin tests_failed++; $display("FAIL zero_r5: got %h expected %h", dut.regs[5], 32'h0); end
    tests_run++; if (dut.regs[6] !== 32'd1) begin tests_failed++; $display("FAIL slt_neg_lt_pos: got %h expected %h", dut.regs[6], 32'd1); end
    tests_run++; if (dut.regs[7] !== 32'd0) begin tests_failed++; $display("FAIL slt_pos_lt_neg: got %h expected %h", dut.regs[7], 32'd0); end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[4] = 32'h1000FFFF; // beq $0,$0,-1 at 0x10
    ack_delay = 0;
    do_reset();
    run(16);
    tests_run++; if (pc !== 32'h10) begin tests_failed++; $display("FAIL beq_reach: got %h expected %h", pc, 32'h10); end
    run(1);
    tests_run++; if (pc !== 32'h14) begin tests_failed++; $display("FAIL beq_fetch_inc: got %h expected %h", pc, 32'h14); end
    run(2);
    tests_run++; if (pc !== 32'h10) begin tests_failed++; $display("FAIL beq_loop1: got %h expected %h", pc, 32'h10); end
    run(3);
    tests_run++; if (pc !== 32'h10) begin tests_failed++; $display("FAIL beq_loop2: got %h expected %h", pc, 32'h10); end
    clear_prog();
    prog[4] = 32'h1400FFFF; // bne $0,$0,-1 at 0x10
    do_reset();
    run(19);
    tests_run++; if (pc !== 32'h14) begin tests_failed++; $display("FAIL bne_fall: got %h expected %h", pc, 32'h14); end
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h14}) begin tests_failed++; $display("FAIL bne_next_fetch: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, 32'h14); end
  endtask

  task automatic test_bgtz();
    clear_prog();
    prog[0] = 32'h2001FFFF; // addi $1,$0,-1
    prog[1] = 32'h1C200001; // bgtz $1,+1 (not taken)
    prog[2] = 32'h20020001; // addi $2,$0,1
    prog[3] = 32'h1C400001; // bgtz $2,+1 (taken)
    prog[4] = 32'h20030005; // addi $3,$0,5 (skipped)
    prog[5] = 32'h20040006; // addi $4,$0,6
    ack_delay = 0;
    do_reset();
    run(18);
    tests_run++; if (dut.regs[3] !== 32'h0) begin tests_failed++; $display("FAIL bgtz_skip: got %h expected %h", dut.regs[3], 32'h0); end
    tests_run++; if (dut.regs[4] !== 32'd6) begin tests_failed++; $display("FAIL bgtz_target: got %h expected %h", dut.regs[4], 32'd6); end
    tests_run++; if (pc !== 32'h18) begin tests_failed++; $display("FAIL bgtz_pc: got %h expected %h", pc, 32'h18); end
  endtask

  task automatic test_mem();
    clear_prog();
    prog[0]  = 32'h0800000C; // j 0x30
    prog[12] = 32'h8C010080; // lw $1,0x80($0)
    prog[13] = 32'hAC010008; // sw $1,8($0)
    prog[14] = 32'h8C040008; // lw $4,8($0)
    prog[32] = 32'hDEADBEEF;
    ack_delay = 3;
    do_reset();
    run(23);
    tests_run++; if ({mem_req, mem_we} !== 2'b11) begin tests_failed++; $display("FAIL sw_strobe: got req=%b we=%b expected 11", mem_req, mem_we); end
    tests_run++; if (mem_addr !== 32'h8) begin tests_failed++; $display("FAIL sw_addr: got %h expected %h", mem_addr, 32'h8); end
    tests_run++; if (mem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_wdata: got %h expected %h", mem_wdata, 32'hDEADBEEF); end
    tests_run++; if (st_count !== 0) begin tests_failed++; $display("FAIL sw_early: got %0d writes expected 0", st_count); end
    run(37);
    tests_run++; if (st_count !== 1) begin tests_failed++; $display("FAIL sw_count: got %0d writes expected 1", st_count); end
    tests_run++; if (st_addr !== 32'h8) begin tests_failed++; $display("FAIL sw_wr_addr: got %h expected %h", st_addr, 32'h8); end
    tests_run++; if (mem[2] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_mem: got %h expected %h", mem[2], 32'hDEADBEEF); end
    tests_run++; if (dut.regs[4] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_r4: got %h expected %h", dut.regs[4], 32'hDEADBEEF); end
  endtask

  task automatic test_halt();
    int bad;
    clear_prog();
    prog[8] = 32'hFC000000; // opcode 0x3F at 0x20
    ack_delay = 0;
    do_reset();
    run(33);
    tests_run++; if (halt !== 1'b0) begin tests_failed++; $display("FAIL halt_early: got %b expected 0", halt); end
    run(1);
    tests_run++; if (halt !== 1'b1) begin tests_failed++; $display("FAIL halt_set: got %b expected 1", halt); end
    tests_run++; if (pc !== 32'h24) begin tests_failed++; $display("FAIL halt_pc: got %h expected %h", pc, 32'h24); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      run(1);
      if (mem_req !== 1'b0 || pc !== 32'h24 || halt !== 1'b1) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL halt_absorb: got %0d bad cycles expected 0", bad); end
    clear_prog();
    prog[0] = 32'h0000003F; // R-type with unsupported funct
    do_reset();
    run(2);
    tests_run++; if ({halt, pc} !== {1'b1, 32'h4}) begin tests_failed++; $display("FAIL halt_funct: got halt=%b pc=%h expected halt=1 pc=%h", halt, pc, 32'h4); end
  endtask

  task automatic test_reset_mid_mem();
    clear_prog();
    prog[0]  = 32'h8C010083; // lw $1,0x83($0) -> issued at 0x80
    prog[32] = 32'h12345678;
    ack_delay = 5;
    do_reset();
    run(8);
    tests_run++; if ({mem_req, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL lw_req: got req=%b we=%b expected 10", mem_req, mem_we); end
    tests_run++; if (mem_addr !== 32'h80) begin tests_failed++; $display("FAIL lw_align: got %h expected %h", mem_addr, 32'h80); end
    run(2);
    ack_delay = 0;
    rstb = 1'b0;
    #1;
    tests_run++; if ({mem_req, mem_we, halt} !== 3'b000) begin tests_failed++; $display("FAIL midrst_clear: got req=%b we=%b halt=%b expected 000", mem_req, mem_we, halt); end
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL midrst_pc: got %h expected %h", pc, 32'h0); end
    #2;
    rstb = 1'b1;
    #1;
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0}) begin tests_failed++; $display("FAIL midrst_refetch: got req=%b we=%b addr=%h expected req=1 we=0 addr=%h", mem_req, mem_we, mem_addr, 32'h0); end
    run(6);
    tests_run++; if (dut.regs[1] !== 32'h12345678) begin tests_failed++; $display("FAIL midrst_lw: got %h expected %h", dut.regs[1], 32'h12345678); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstb         = 1'b0;
    ack_delay    = 0;
    clear_prog();
    test_reset();
    test_arith();
    test_alu();
    test_zero_slt();
    test_branch();
    test_bgtz();
    test_mem();
    test_halt();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
